// File: rtl/i2c_target_regs.sv
// I2C target register file: 7-bit address match, pointer byte then burst writes, current-address burst reads.
// Optional macro I2C_TGT_SYNC_EN inserts 2-flop synchronizers on scl_i/sda_i ahead of edge detection.
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h08,
  parameter int         NUM_REGS = 16,
  localparam int        PW       = $clog2(NUM_REGS)
) (
  input  logic          scl_4x,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_o,
  output logic          busy,
  output logic          reg_wr_en,
  output logic [PW-1:0] reg_wr_addr,
  output logic [7:0]    reg_wr_data
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;

  logic scl, sda;

`ifdef I2C_TGT_SYNC_EN
  logic [1:0] scl_sync_reg, sda_sync_reg;

  always_ff @(posedge scl_4x) begin
    if (rst) begin
      scl_sync_reg <= 2'b11;
      sda_sync_reg <= 2'b11;
    end else begin
      scl_sync_reg <= {scl_sync_reg[0], scl_i};
      sda_sync_reg <= {sda_sync_reg[0], sda_i};
    end
  end

  assign scl = scl_sync_reg[1];
  assign sda = sda_sync_reg[1];
`else
  assign scl = scl_i;
  assign sda = sda_i;
`endif

  // Previous samples start high so an idle bus right after reset never looks like a START.
  logic scl_q, sda_q;

  always_ff @(posedge scl_4x) begin
    if (rst) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl;
      sda_q <= sda;
    end
  end

  logic rise, fall, start_det, stop_det;
  assign rise      = ~scl_q & scl;
  assign fall      = scl_q & ~scl;
  assign start_det = scl & scl_q & sda_q & ~sda;
  assign stop_det  = scl & scl_q & ~sda_q & sda;

  state_t        state_reg;
  logic [3:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic [7:0]    tx_reg;
  logic          rw_reg;
  logic [PW-1:0] ptr_reg;
  logic          sda_o_reg;
  logic          busy_reg;
  logic          wr_en_reg;
  logic [PW-1:0] wr_addr_reg;
  logic [7:0]    wr_data_reg;

  logic [7:0] reg_file [NUM_REGS];
  logic [7:0] rd_byte;
  logic [7:0] shift_in;

  assign rd_byte  = reg_file[ptr_reg];
  assign shift_in = {shift_reg[6:0], sda};

  always_ff @(posedge scl_4x) begin
    if (rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= 4'd0;
      shift_reg   <= 8'h00;
      tx_reg      <= 8'h00;
      rw_reg      <= 1'b0;
      ptr_reg     <= '0;
      sda_o_reg   <= 1'b1;
      busy_reg    <= 1'b0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= 8'h00;
    end else begin
      wr_en_reg <= 1'b0;
      if (stop_det) begin
        state_reg   <= IDLE;
        sda_o_reg   <= 1'b1;
        busy_reg    <= 1'b0;
        bit_cnt_reg <= 4'd0;
      end else if (start_det) begin
        state_reg   <= ADDR;
        sda_o_reg   <= 1'b1;
        busy_reg    <= 1'b1;
        bit_cnt_reg <= 4'd0;
      end else begin
        case (state_reg)
          IDLE: ;
          ADDR: begin
            if (rise) begin
              shift_reg   <= shift_in;
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end else if (fall && bit_cnt_reg == 4'd8) begin
              bit_cnt_reg <= 4'd0;
              if (shift_reg[7:1] == DEV_ADDR) begin
                rw_reg    <= shift_reg[0];
                sda_o_reg <= 1'b0;
                state_reg <= ADDR_ACK;
              end else begin
                busy_reg  <= 1'b0;
                state_reg <= IDLE;
              end
            end
          end
          // A read's MSB goes out on the same fall that ends the address ACK.
          ADDR_ACK: begin
            if (fall) begin
              if (rw_reg) begin
                sda_o_reg   <= rd_byte[7];
                tx_reg      <= {rd_byte[6:0], 1'b0};
                bit_cnt_reg <= 4'd1;
                state_reg   <= RDATA;
              end else begin
                sda_o_reg   <= 1'b1;
                bit_cnt_reg <= 4'd0;
                state_reg   <= PTR;
              end
            end
          end
          PTR: begin
            if (rise) begin
              shift_reg   <= shift_in;
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end else if (fall && bit_cnt_reg == 4'd8) begin
              ptr_reg     <= shift_reg[PW-1:0];
              sda_o_reg   <= 1'b0;
              bit_cnt_reg <= 4'd0;
              state_reg   <= PTR_ACK;
            end
          end
          PTR_ACK: begin
            if (fall) begin
              sda_o_reg <= 1'b1;
              state_reg <= WDATA;
            end
          end
          WDATA: begin
            if (rise) begin
              shift_reg   <= shift_in;
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              if (bit_cnt_reg == 4'd7) begin
                wr_en_reg   <= 1'b1;
                wr_addr_reg <= ptr_reg;
                wr_data_reg <= shift_in;
              end
            end else if (fall && bit_cnt_reg == 4'd8) begin
              sda_o_reg   <= 1'b0;
              bit_cnt_reg <= 4'd0;
              state_reg   <= WDATA_ACK;
            end
          end
          WDATA_ACK: begin
            if (fall) begin
              sda_o_reg <= 1'b1;
              ptr_reg   <= ptr_reg + 1'b1;
              state_reg <= WDATA;
            end
          end
          // bit_cnt counts bits already driven; 0 means the next byte has not been loaded yet.
          RDATA: begin
            if (fall) begin
              if (bit_cnt_reg == 4'd0) begin
                sda_o_reg   <= rd_byte[7];
                tx_reg      <= {rd_byte[6:0], 1'b0};
                bit_cnt_reg <= 4'd1;
              end else if (bit_cnt_reg == 4'd8) begin
                sda_o_reg   <= 1'b1;
                bit_cnt_reg <= 4'd0;
                state_reg   <= RDATA_ACK;
              end else begin
                sda_o_reg   <= tx_reg[7];
                tx_reg      <= {tx_reg[6:0], 1'b0};
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
              end
            end
          end
          RDATA_ACK: begin
            if (rise) begin
              if (!sda) begin
                ptr_reg     <= ptr_reg + 1'b1;
                bit_cnt_reg <= 4'd0;
                state_reg   <= RDATA;
              end else begin
                state_reg <= WAIT_STOP;
              end
            end
          end
          WAIT_STOP: sda_o_reg <= 1'b1;
          default: begin
            state_reg <= IDLE;
            sda_o_reg <= 1'b1;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Storage is committed from the registered write strobe, one cycle behind the pulse.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [7:0] val_reg;

      always_ff @(posedge scl_4x) begin
        if (rst) begin
          val_reg <= 8'h00;
        end else if (wr_en_reg && wr_addr_reg == PW'(gi)) begin
          val_reg <= wr_data_reg;
        end
      end

      assign reg_file[gi] = val_reg;
    end
  endgenerate

  assign sda_o       = sda_o_reg;
  assign busy        = busy_reg;
  assign reg_wr_en   = wr_en_reg;
  assign reg_wr_addr = wr_addr_reg;
  assign reg_wr_data = wr_data_reg;

endmodule
